// File: rtl/sram_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_initiator_pkg
// Description : Shared types and constants for the SRAM initiator: FSM state
//               encoding, host transfer-size codes, wait-length limits.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_initiator_pkg;

   // One byte cycle walks SETUP -> ACCESS -> HOLD; words insert NEXT between
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      HOLD   = 3'd3,
      NEXT   = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   // The access counter is 4 bits wide and a zero-length access is meaningless
   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 15;

endpackage
`default_nettype wire

// File: rtl/sram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : sram_initiator
// Description : Host-side controller for a 32Kx8 asynchronous SRAM. Takes byte
//               or 16-bit little-endian requests, splits words into two byte
//               cycles and sequences setup / access / hold on registered pins.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_initiator
   import sram_initiator_pkg::*;
#(
   parameter int ADDR_W      = 15,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_req,
   output logic              host_ready,
   input  logic              host_we,
   input  logic              host_size,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [15:0]       host_wdata,
   output logic              host_done,
   output logic [15:0]       host_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_wdata,
   output logic              sram_wr_en,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   input  logic [7:0]        sram_rdata
);

   if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_wait_range_check
      $error("sram_initiator: WAIT_CYCLES must lie in 1..15");
   end

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  wait_cnt;
   logic        we_lat;
   logic        size_lat;
   logic        second;      // set while the high byte of a word is in flight
   logic [7:0]  wdata_hi;
   logic [15:0] rd_cap;      // bytes collected from the SRAM before publishing
   logic        accept;

   assign host_ready = (state == IDLE);
   assign host_done  = (state == DONE);
   assign accept     = (state == IDLE) && host_req;

   // Next-state decode for the byte-cycle sequencer
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (host_req) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (wait_cnt == 4'd1) state_nxt = HOLD;
         HOLD:    state_nxt = (size_lat == SZ_BYTE || second) ? DONE : NEXT;
         NEXT:    state_nxt = SETUP;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and access-phase down-counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state <= state_nxt;
         if (state != ACCESS && state_nxt == ACCESS)
            wait_cnt <= WAIT_LOAD;
         else if (state == ACCESS)
            wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Request latching, byte sequencing and read-data assembly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_lat     <= 1'b0;
         size_lat   <= SZ_BYTE;
         second     <= 1'b0;
         wdata_hi   <= 8'h00;
         rd_cap     <= 16'h0000;
         host_rdata <= 16'h0000;
      end else begin
         if (accept) begin
            we_lat   <= host_we;
            size_lat <= host_size;
            wdata_hi <= host_wdata[15:8];
            second   <= 1'b0;
         end else if (state_nxt == NEXT) begin
            second   <= 1'b1;
         end
         // SRAM data is combinational from the address, so it is settled by the
         // final access edge
         if (state == ACCESS && wait_cnt == 4'd1 && !we_lat) begin
            if (second) rd_cap[15:8] <= sram_rdata;
            else        rd_cap[7:0]  <= sram_rdata;
         end
         // Publish only once the whole request is in, so host_rdata never shows
         // a half-updated word
         if (state == HOLD && state_nxt == DONE && !we_lat)
            host_rdata <= (size_lat == SZ_WORD) ? rd_cap : {8'h00, rd_cap[7:0]};
      end
   end

   // Registered SRAM pins, derived from the state being entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_addr  <= '0;
         sram_wdata <= 8'h00;
         sram_wr_en <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
      end else begin
         sram_wr_en <= (state_nxt == ACCESS) && we_lat;
         sram_oe_n  <= !((state_nxt == ACCESS) && !we_lat);
         sram_ce_n  <= (state_nxt == IDLE) || (state_nxt == DONE);
         if (accept) begin
            sram_addr  <= host_addr;
            sram_wdata <= host_wdata[7:0];
         end else if (state_nxt == NEXT) begin
            // Natural wrap at the top of the array
            sram_addr  <= sram_addr + ADDR_W'(1);
            sram_wdata <= wdata_hi;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_initiator
// Description : Self-checking bench for sram_initiator with behavioural SRAM
//               models; expected read data is queued at issue and compared at
//               completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_initiator;

   localparam int ADDR_W = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Fast instance (WAIT_CYCLES = 1)
   logic              host_req, host_we, host_size, host_ready, host_done;
   logic [ADDR_W-1:0] host_addr;
   logic [15:0]       host_wdata, host_rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic [7:0]        sram_wdata, sram_rdata;
   logic              sram_wr_en, sram_ce_n, sram_oe_n;

   // Slow instance (WAIT_CYCLES = 3)
   logic              slow_req, slow_we, slow_size, slow_ready, slow_done;
   logic [ADDR_W-1:0] slow_haddr;
   logic [15:0]       slow_wdata16, slow_rdata16;
   logic [ADDR_W-1:0] slow_addr;
   logic [7:0]        slow_wdata, slow_rdata;
   logic              slow_wr_en, slow_ce_n, slow_oe_n;

   logic [7:0] mem      [0:32767];
   logic [7:0] slow_mem [0:32767];

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q [$];

   sram_initiator #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .host_req(host_req), .host_ready(host_ready), .host_we(host_we),
      .host_size(host_size), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_done(host_done), .host_rdata(host_rdata),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wr_en(sram_wr_en),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_rdata(sram_rdata)
   );

   sram_initiator #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) dut_slow (
      .clk(clk), .rst(rst),
      .host_req(slow_req), .host_ready(slow_ready), .host_we(slow_we),
      .host_size(slow_size), .host_addr(slow_haddr), .host_wdata(slow_wdata16),
      .host_done(slow_done), .host_rdata(slow_rdata16),
      .sram_addr(slow_addr), .sram_wdata(slow_wdata), .sram_wr_en(slow_wr_en),
      .sram_ce_n(slow_ce_n), .sram_oe_n(slow_oe_n), .sram_rdata(slow_rdata)
   );

   // Behavioural SRAMs: synchronous write, combinational read
   always @(posedge clk) if (!sram_ce_n && sram_wr_en) mem[sram_addr] <= sram_wdata;
   always @(posedge clk) if (!slow_ce_n && slow_wr_en) slow_mem[slow_addr] <= slow_wdata;
   assign sram_rdata = mem[sram_addr];
   assign slow_rdata = slow_mem[slow_addr];

   // Pin-level invariants on both instances
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         total++;
         assert (!(sram_wr_en && !sram_oe_n) && !(sram_wr_en && sram_ce_n) &&
                 !(slow_wr_en && !slow_oe_n) && !(slow_wr_en && slow_ce_n))
         else begin
            bad++;
            $error("FAIL invariant: wr_en=%b oe_n=%b ce_n=%b slow wr_en=%b oe_n=%b ce_n=%b required no overlap",
                   sram_wr_en, sram_oe_n, sram_ce_n, slow_wr_en, slow_oe_n, slow_ce_n);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] fast_pins();
      return 64'({host_ready, host_done, host_rdata, sram_addr, sram_wdata,
                  sram_wr_en, sram_ce_n, sram_oe_n});
   endfunction

   localparam logic [63:0] RESET_PINS = 64'({1'b1, 1'b0, 16'h0000, 15'h0000, 8'h00,
                                             1'b0, 1'b1, 1'b1});

   // Issue one request on the fast instance and check completion latency/data
   task automatic run_txn(input string tag, input logic we, input logic size,
                          input logic [ADDR_W-1:0] addr, input logic [15:0] wdata,
                          input int exp_lat, input logic [15:0] exp_rd);
      int  lat;
      bit  seen;
      logic [15:0] exp_v;
      @(negedge clk);
      for (int k = 0; k < 50 && !host_ready; k++) @(negedge clk);
      check({tag, " ready"}, 64'(host_ready), 64'd1);
      host_req = 1'b1; host_we = we; host_size = size;
      host_addr = addr; host_wdata = wdata;
      if (!we) exp_q.push_back(exp_rd);
      @(posedge clk);
      #1 host_req = 1'b0;
      seen = 0; lat = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (host_done) begin seen = 1; lat = i; end
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      if (!we) begin
         exp_v = exp_q.pop_front();
         check({tag, " rdata"}, 64'(host_rdata), 64'(exp_v));
      end
   endtask

   initial begin
      int  lat, lat2, oe_cnt;
      bit  clean, found;
      logic [15:0] exp_v;

      for (int i = 0; i < 32768; i++) begin
         mem[i]      = 8'h00;
         slow_mem[i] = 8'(i) ^ 8'hA5;
      end
      host_req = 0; host_we = 0; host_size = 0; host_addr = '0; host_wdata = '0;
      slow_req = 0; slow_we = 0; slow_size = 0; slow_haddr = '0; slow_wdata16 = '0;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1 check("reset pins", fast_pins(), RESET_PINS);
      check("reset slow", 64'({slow_ready, slow_done, slow_rdata16, slow_ce_n, slow_oe_n, slow_wr_en}),
            64'({1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0}));
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Byte write then read back
      run_txn("byte wr", 1'b1, 1'b0, 15'h0123, 16'h005A, 4, 16'h0000);
      check("byte wr mem", 64'(mem[15'h0123]), 64'h5A);
      run_txn("byte rd", 1'b0, 1'b0, 15'h0123, 16'h0000, 4, 16'h005A);

      // Word write/read, little-endian
      run_txn("word wr", 1'b1, 1'b1, 15'h0010, 16'hBEEF, 8, 16'h0000);
      check("word wr lo", 64'(mem[15'h0010]), 64'hEF);
      check("word wr hi", 64'(mem[15'h0011]), 64'hBE);
      run_txn("word rd", 1'b0, 1'b1, 15'h0010, 16'h0000, 8, 16'hBEEF);
      run_txn("byte rd zext", 1'b0, 1'b0, 15'h0011, 16'h0000, 4, 16'h00BE);

      // Word write across the top of the array; writes leave host_rdata alone
      run_txn("wrap wr", 1'b1, 1'b1, 15'h7FFF, 16'h1234, 8, 16'h0000);
      check("rdata kept on write", 64'(host_rdata), 64'h00BE);
      check("wrap lo", 64'(mem[15'h7FFF]), 64'h34);
      check("wrap hi", 64'(mem[15'h0000]), 64'h12);
      run_txn("wrap rd", 1'b0, 1'b1, 15'h7FFF, 16'h0000, 8, 16'h1234);

      // Slow instance: byte read with three access cycles
      @(negedge clk);
      slow_req = 1'b1; slow_we = 1'b0; slow_size = 1'b0; slow_haddr = 15'h0042;
      exp_q.push_back(16'h00E7);
      @(posedge clk);
      #1 slow_req = 1'b0;
      oe_cnt = 0; lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!slow_oe_n) oe_cnt++;
         if (slow_done && lat == 0) lat = i;
      end
      check("slow latency", 64'(lat), 64'd6);
      check("slow oe cycles", 64'(oe_cnt), 64'd3);
      exp_v = exp_q.pop_front();
      check("slow rdata", 64'(slow_rdata16), 64'(exp_v));

      // Request held high with wandering address during a busy word write
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_size = 1'b1;
      host_addr = 15'h0200; host_wdata = 16'hA55A;
      @(posedge clk);
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (host_done && lat == 0) lat = i;
         host_addr  = 15'h0300 + 15'(i);
         host_wdata = 16'h1100 + 16'(i);
      end
      check("held latency", 64'(lat), 64'd8);
      @(negedge clk);
      check("held ready after done", 64'(host_ready), 64'd1);
      host_size = 1'b0; host_addr = 15'h0400; host_wdata = 16'h0077;
      @(negedge clk);
      check("held re-accept", 64'(host_ready), 64'd0);
      host_req = 1'b0;
      lat2 = 0;
      for (int j = 2; j <= 20 && lat2 == 0; j++) begin
         @(negedge clk);
         if (host_done) lat2 = j;
      end
      check("held second latency", 64'(lat2), 64'd4);
      check("held mem", 64'({mem[15'h0201], mem[15'h0200], mem[15'h0400]}), 64'hA55A77);
      clean = 1;
      for (int a = 15'h0301; a <= 15'h0308; a++) if (mem[a] !== 8'h00) clean = 0;
      check("held ignored addrs", 64'(clean), 64'd1);

      // Reset during the access phase of a word write
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_size = 1'b1;
      host_addr = 15'h2000; host_wdata = 16'hCAFE;
      @(posedge clk);
      #1 host_req = 1'b0;
      found = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         @(negedge clk);
         if (sram_wr_en) found = 1;
      end
      check("reach access", 64'(found), 64'd1);
      #1 rst = 1'b0;
      #1 check("mid-op reset pins", fast_pins(), RESET_PINS);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      found = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (host_done || !host_ready) found = 1;
      end
      check("no done after abort", 64'(found), 64'd0);
      check("aborted hi byte", 64'(mem[15'h2001]), 64'h00);
      run_txn("post-reset rd", 1'b0, 1'b0, 15'h0123, 16'h0000, 4, 16'h005A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_initiator.md
Name: sram_initiator

Overview:
Host-side controller that drives the 32Kx8 static RAM pin interface: address, write data, write enable, chip and output enables, and captured read data.
- Accepts byte or 16-bit little-endian read/write requests from a simple req/ready host port.
- Splits 16-bit requests into two sequential byte cycles.
- Enforces programmable setup, access and hold timing.
- Sits between the CPU bus fabric and the SRAM model or device.

Parameters:
ADDR_W, 15, SRAM byte address width (32768 locations)
WAIT_CYCLES, 1, access-phase length per byte in clk cycles; legal range 1..15

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
host_req  in  1  request valid
host_ready  out  1  controller idle, can accept a request
host_we  in  1  1 = write, 0 = read
host_size  in  1  0 = byte, 1 = 16-bit (low byte at addr, high byte at addr+1)
host_addr  in  ADDR_W  byte address
host_wdata  in  16  write data; byte access uses [7:0]
host_done  out  1  one-cycle completion pulse
host_rdata  out  16  read result; byte read zero-extends into [15:8]
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  8  SRAM write data
sram_wr_en  out  1  SRAM write enable, active-high, sampled on clk by the SRAM
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_rdata  in  8  SRAM read data, combinational from sram_addr

Behaviour:
Reset values (rst low, applies immediately, asynchronous):
- state IDLE, host_ready=1, host_done=0, host_rdata=0.
- sram_addr=0, sram_wdata=0, sram_wr_en=0, sram_ce_n=1, sram_oe_n=1.
- Reset mid-operation aborts the access at once. Any in-flight write may leave at most the byte already clocked. No done pulse is issued for the aborted request.

Request acceptance:
- A request is accepted on the rising edge where host_req=1 and host_ready=1. Call this edge T0.
- At T0 the controller latches we, size, addr and wdata. host_ready drops to 0 the next cycle.
- Host inputs are ignored while host_ready=0.

State machine: IDLE, SETUP, ACCESS, HOLD, NEXT, DONE.
- IDLE -> SETUP on accept.
  - sram_addr = latched addr.
  - sram_wdata = byte 0.
  - sram_ce_n = 0.
- SETUP (1 cycle) -> ACCESS.
  - Address and data are stable.
  - sram_wr_en = 0 and sram_oe_n = 1.
- ACCESS (WAIT_CYCLES cycles, 4-bit down-counter) -> HOLD.
  - Write: sram_wr_en = 1 for every ACCESS cycle.
  - Read: sram_oe_n = 0, and sram_rdata is captured on the last ACCESS cycle edge.
- HOLD (1 cycle):
  - sram_wr_en = 0 and sram_oe_n = 1; address and data are held.
  - Byte request, or second byte of a word: -> DONE.
  - First byte of a word: -> NEXT.
- NEXT (1 cycle) -> SETUP.
  - sram_addr = addr+1, modulo 2^ADDR_W, so 0x7FFF wraps to 0x0000.
  - sram_wdata = byte 1 (host_wdata[15:8]).
- DONE (1 cycle) -> IDLE.
  - host_done = 1.
  - host_rdata is valid and is held until the next read completes.
  - sram_ce_n = 1.
  - host_ready returns to 1 in the following cycle.

Timing:
- host_done is high in cycle T0 + WAIT_CYCLES + 3 for a byte access.
- host_done is high in cycle T0 + 2*WAIT_CYCLES + 6 for a word access.
- WAIT_CYCLES=1: byte done at T4, word done at T8.

Invariants:
- sram_wr_en and sram_oe_n active together: never.
- sram_wr_en high outside ACCESS: never.
- All sram_* outputs are registered.
- host_rdata is written only on reads; write requests leave it unchanged.

Decomposition:
Package sram_initiator_pkg holds:
- the state enum (IDLE, SETUP, ACCESS, HOLD, NEXT, DONE);
- the size encodings SZ_BYTE=0 and SZ_WORD=1;
- the WAIT_CYCLES legal-range constants, checked by an elaboration-time assertion.

No sub-module is needed. The wait counter and the byte-lane mux stay inline.

Test Plan:
- Byte write 0x5A to 0x0123, then byte read 0x0123 -> SRAM[0x0123]=0x5A; host_rdata=0x005A; each host_done at T0+4.
- Word write 0xBEEF to 0x0010, then word read -> SRAM[0x10]=0xEF, SRAM[0x11]=0xBE; host_rdata=0xBEEF; host_done at T0+8.
- Word write 0x1234 to 0x7FFF -> SRAM[0x7FFF]=0x34, SRAM[0x0000]=0x12 (wrap); word read back returns 0x1234.
- WAIT_CYCLES=3, byte read -> sram_oe_n low for exactly 3 cycles; host_done at T0+6; wr_en and oe_n never simultaneously active.
- host_req held high with changing addr during a busy word write -> only the first request is performed; the next accept occurs in the cycle after DONE.
- rst low during ACCESS of a word write -> all outputs take reset values immediately; no host_done; host_ready=1 after release; a subsequent byte read completes normally.
